// File: rtl/cmd_dispatcher.sv
// cmd_dispatcher: decodes UART command bytes against a per-channel opcode
// table, starts the matching sub-controller and waits for its done, with a
// watchdog timeout. State is shown on status LEDs plus a sticky error code.
// Optional macro CMD_DISP_QUEUE_EN adds a one-entry pending slot for a byte
// that arrives while a channel is busy; without it such bytes are dropped
// and flagged as overrun.
module cmd_dispatcher #(
    parameter int                       DATA_W      = 8,
    parameter int                       NUM_CH      = 2,
    parameter logic [NUM_CH*DATA_W-1:0] CMD_TABLE   = {8'h0F, 8'hF0},
    parameter int                       TIMEOUT_CYC = 1000000,
    parameter int                       START_PULSE = 0,
    parameter int                       STAT_W      = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rxrdy,
    input  logic [DATA_W-1:0] rxdw,
    input  logic [NUM_CH-1:0] done,
    output logic [NUM_CH-1:0] start,
    output logic              busy,
    output logic              cmd_ack,
    output logic [1:0]        err_code,
    output logic [STAT_W-1:0] sleds
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    // Counter value seen during the last allowed BUSY cycle.
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_OPCODE  = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_OVERRUN = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    state_t            state;
    logic [CH_W-1:0]   act_ch;
    logic [CNT_W-1:0]  cnt;

    logic              dec_vld;
    logic [DATA_W-1:0] dec_byte;
    logic [CH_W:0]     dec_res;
    logic              dec_hit;
    logic [CH_W-1:0]   dec_ch;
    logic              done_act;
    logic              timeout_hit;

`ifdef CMD_DISP_QUEUE_EN
    logic              slot_full;
    logic [DATA_W-1:0] slot_data;
`endif

    // Returns {hit, index}; scanning downwards lets the lowest match win.
    function automatic logic [CH_W:0] match_opcode(input logic [DATA_W-1:0] b);
        logic [CH_W:0] r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (CMD_TABLE[i*DATA_W +: DATA_W] == b) begin
                r = {1'b1, CH_W'(i)};
            end
        end
        return r;
    endfunction

    // Select the byte to decode when idle: a pending byte takes priority
    // over a freshly received one.
    always_comb begin
        dec_vld  = rxrdy;
        dec_byte = rxdw;
`ifdef CMD_DISP_QUEUE_EN
        if (slot_full) begin
            dec_vld  = 1'b1;
            dec_byte = slot_data;
        end
`endif
        dec_res = match_opcode(dec_byte);
        dec_hit = dec_res[CH_W];
        dec_ch  = dec_res[CH_W-1:0];
    end

    assign done_act    = done[act_ch];
    assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt == CNT_LAST);

    // Main control FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            act_ch   <= '0;
            cnt      <= '0;
            start    <= '0;
            busy     <= 1'b0;
            cmd_ack  <= 1'b0;
            err_code <= ERR_NONE;
            sleds    <= '0;
`ifdef CMD_DISP_QUEUE_EN
            slot_full <= 1'b0;
            slot_data <= '0;
`endif
        end else begin
            cmd_ack <= 1'b0;
            case (state)
                ST_IDLE, ST_ERROR: begin
`ifdef CMD_DISP_QUEUE_EN
                    // The pending byte is consumed now; a byte arriving in the
                    // same cycle takes its place.
                    if (slot_full) begin
                        slot_full <= rxrdy;
                        if (rxrdy) begin
                            slot_data <= rxdw;
                        end
                    end
`endif
                    if (dec_vld) begin
                        if (dec_hit) begin
                            state    <= ST_BUSY;
                            act_ch   <= dec_ch;
                            cnt      <= '0;
                            start    <= NUM_CH'(1) << dec_ch;
                            busy     <= 1'b1;
                            cmd_ack  <= 1'b1;
                            err_code <= ERR_NONE;
                            sleds    <= STAT_W'(dec_ch) + STAT_W'(1);
                        end else begin
                            state    <= ST_ERROR;
                            start    <= '0;
                            busy     <= 1'b0;
                            err_code <= ERR_OPCODE;
                            sleds    <= '1;
                        end
                    end
                end

                ST_BUSY: begin
                    cnt <= cnt + CNT_W'(1);
                    if (START_PULSE != 0) begin
                        start <= '0;
                    end

                    // A byte during BUSY is handled first so that a timeout in
                    // the same cycle overrides its effect.
                    if (rxrdy) begin
`ifdef CMD_DISP_QUEUE_EN
                        if (!slot_full) begin
                            slot_full <= 1'b1;
                            slot_data <= rxdw;
                        end else begin
                            err_code <= ERR_OVERRUN;
                        end
`else
                        err_code <= ERR_OVERRUN;
`endif
                    end

                    if (done_act) begin
                        state <= ST_IDLE;
                        start <= '0;
                        busy  <= 1'b0;
                        sleds <= '0;
                    end else if (timeout_hit) begin
                        state    <= ST_ERROR;
                        start    <= '0;
                        busy     <= 1'b0;
                        err_code <= ERR_TIMEOUT;
                        sleds    <= '1;
`ifdef CMD_DISP_QUEUE_EN
                        slot_full <= 1'b0;
`endif
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    start <= '0;
                    busy  <= 1'b0;
                    sleds <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_dispatcher.sv
// Testbench for cmd_dispatcher: directed vector table, multi-cycle corner
// sequences and random traffic checked against a behavioural model.
module tb_cmd_dispatcher;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxrdy = 1'b0;
    logic [7:0] rxdw = 8'h00;
    logic [1:0] done = 2'b00;

    logic [1:0] start, start_p;
    logic       busy, busy_p, ack, ack_p;
    logic [1:0] err, err_p, sleds, sleds_p;
    logic [8:0] dut_vec, pul_vec;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cmd_dispatcher #(.DATA_W(8), .NUM_CH(2), .CMD_TABLE({8'h0F, 8'hF0}),
                     .TIMEOUT_CYC(TO), .START_PULSE(0), .STAT_W(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .rxrdy(rxrdy), .rxdw(rxdw), .done(done),
        .start(start), .busy(busy), .cmd_ack(ack), .err_code(err), .sleds(sleds));

    cmd_dispatcher #(.DATA_W(8), .NUM_CH(2), .CMD_TABLE({8'h0F, 8'hF0}),
                     .TIMEOUT_CYC(TO), .START_PULSE(1), .STAT_W(2)) u_pulse (
        .clk(clk), .rst_n(rst_n), .rxrdy(rxrdy), .rxdw(rxdw), .done(done),
        .start(start_p), .busy(busy_p), .cmd_ack(ack_p), .err_code(err_p), .sleds(sleds_p));

    assign dut_vec = {start, busy, ack, err, sleds};
    assign pul_vec = {start_p, busy_p, ack_p, err_p, sleds_p};

    // ---------------- behavioural model ----------------
    // mode: 0 idle, 1 busy, 2 error
    int   m_state, m_ch, m_cyc, m_err;
    bit   m_ack;
    int   m_q[$];
    logic [7:0] opcodes [2] = '{8'hF0, 8'h0F};

    function automatic int lookup(input logic [7:0] b);
        for (int i = 0; i < 2; i++) if (opcodes[i] == b) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_state = 0; m_ch = 0; m_cyc = 0; m_err = 0; m_ack = 0;
        m_q.delete();
    endtask

    task automatic model_step(input logic r, input logic [7:0] b, input logic [1:0] d);
        bit have;
        logic [7:0] nb;
        int ch;
        m_ack = 0;
        have = 0;
        nb = 8'h00;
        if (m_state != 1) begin
            if (m_q.size() > 0) begin
                nb = 8'(m_q.pop_front());
                have = 1;
                if (r) m_q.push_back(int'(b));
            end else if (r) begin
                nb = b;
                have = 1;
            end
            if (have) begin
                ch = lookup(nb);
                if (ch >= 0) begin
                    m_state = 1; m_ch = ch; m_cyc = 0; m_ack = 1; m_err = 0;
                end else begin
                    m_state = 2; m_err = 1;
                end
            end
        end else begin
            m_cyc++;
            if (r) begin
`ifdef CMD_DISP_QUEUE_EN
                if (m_q.size() == 0) m_q.push_back(int'(b));
                else m_err = 3;
`else
                m_err = 3;
`endif
            end
            if (d[m_ch]) begin
                m_state = 0;
            end else if (m_cyc == TO) begin
                m_state = 2; m_err = 2;
                m_q.delete();
            end
        end
    endtask

    function automatic logic [8:0] model_out(input bit pulse);
        logic [1:0] s, l;
        s = 2'b00;
        l = 2'b00;
        if (m_state == 1) begin
            l = 2'(m_ch + 1);
            if (!pulse || m_cyc == 0) s = 2'(1 << m_ch);
        end else if (m_state == 2) begin
            l = 2'b11;
        end
        return {s, (m_state == 1), m_ack, 2'(m_err), l};
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic cycle(input logic r, input logic [7:0] b, input logic [1:0] d, input string tag);
        logic [8:0] e0, e1;
        rxrdy = r; rxdw = b; done = d;
        model_step(r, b, d);
        @(posedge clk);
        #1;
        e0 = model_out(0);
        e1 = model_out(1);
        check({tag, " dut"}, 16'(dut_vec), 16'(e0));
        check({tag, " pulse"}, 16'(pul_vec), 16'(e1));
        rxrdy = 1'b0; done = 2'b00;
    endtask

    typedef struct {
        logic       r;
        logic [7:0] b;
        logic [1:0] d;
        logic [8:0] exp;   // {start, busy, cmd_ack, err_code, sleds}
    } vec_t;

    vec_t tbl[11];

    initial begin
        int nb;
        logic [1:0] rd;
        logic [7:0] rb;

        tbl[0]  = '{1'b1, 8'hF0, 2'b00, 9'b01_1_1_00_01};
        tbl[1]  = '{1'b0, 8'h00, 2'b00, 9'b01_1_0_00_01};
        tbl[2]  = '{1'b0, 8'h00, 2'b00, 9'b01_1_0_00_01};
        tbl[3]  = '{1'b0, 8'h00, 2'b01, 9'b00_0_0_00_00};
        tbl[4]  = '{1'b1, 8'h0F, 2'b00, 9'b10_1_1_00_10};
        tbl[5]  = '{1'b0, 8'h00, 2'b01, 9'b10_1_0_00_10};
        tbl[6]  = '{1'b0, 8'h00, 2'b10, 9'b00_0_0_00_00};
        tbl[7]  = '{1'b1, 8'hAA, 2'b00, 9'b00_0_0_01_11};
        tbl[8]  = '{1'b0, 8'h00, 2'b00, 9'b00_0_0_01_11};
        tbl[9]  = '{1'b1, 8'hF0, 2'b00, 9'b01_1_1_00_01};
        tbl[10] = '{1'b0, 8'h00, 2'b01, 9'b00_0_0_00_00};

        // Reset state
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset dut", 16'(dut_vec), 16'h0);
        check("reset pulse", 16'(pul_vec), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vector table
        for (int i = 0; i < 11; i++) begin
            cycle(tbl[i].r, tbl[i].b, tbl[i].d, "tbl");
            check($sformatf("tbl[%0d]", i), 16'(dut_vec), 16'(tbl[i].exp));
        end

        // Watchdog: exactly TO busy cycles then ERROR
        cycle(1'b1, 8'hF0, 2'b00, "to_go");
        nb = 0;
        for (int k = 0; k < 40 && busy; k++) begin
            nb++;
            cycle(1'b0, 8'h00, 2'b00, "to_wait");
        end
        check("to_busy_cycles", 16'(nb), 16'(TO));
        check("to_err", 16'(err), 16'h2);
        check("to_start", 16'(start), 16'h0);
        check("to_sleds", 16'(sleds), 16'h3);

        // done on the final allowed cycle wins over timeout
        cycle(1'b1, 8'hF0, 2'b00, "tod_go");
        for (int k = 0; k < TO - 1; k++) cycle(1'b0, 8'h00, 2'b00, "tod_wait");
        cycle(1'b0, 8'h00, 2'b01, "tod_done");
        check("tod_busy", 16'(busy), 16'h0);
        check("tod_err", 16'(err), 16'h0);

        // Byte received while busy
        cycle(1'b1, 8'hF0, 2'b00, "ovr_go");
        cycle(1'b1, 8'h0F, 2'b00, "ovr_byte");
`ifdef CMD_DISP_QUEUE_EN
        check("q_stored_err", 16'(err), 16'h0);
        cycle(1'b1, 8'hAA, 2'b00, "q_third");
        check("q_third_err", 16'(err), 16'h3);
        cycle(1'b0, 8'h00, 2'b01, "q_done0");
        check("q_gap_busy", 16'(busy), 16'h0);
        cycle(1'b0, 8'h00, 2'b00, "q_dispatch");
        check("q_ch1_start", 16'(start), 16'h2);
        check("q_ch1_ack", 16'(ack), 16'h1);
        cycle(1'b0, 8'h00, 2'b10, "q_done1");
`else
        check("ovr_err", 16'(err), 16'h3);
        check("ovr_start", 16'(start), 16'h1);
        cycle(1'b0, 8'h00, 2'b01, "ovr_done");
        check("ovr_sticky", 16'(err), 16'h3);
        cycle(1'b0, 8'h00, 2'b00, "ovr_idle");
        check("ovr_no_dispatch", 16'(busy), 16'h0);
`endif

        // Asynchronous reset while busy
        cycle(1'b1, 8'hF0, 2'b00, "rst_go");
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_async dut", 16'(dut_vec), 16'h0);
        check("rst_async pulse", 16'(pul_vec), 16'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_release", 16'(dut_vec), 16'h0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            case ($urandom % 4)
                0: rb = 8'hF0;
                1: rb = 8'h0F;
                2: rb = 8'hAA;
                default: rb = 8'($urandom);
            endcase
            rd[0] = ($urandom % 6) == 0;
            rd[1] = ($urandom % 6) == 0;
            cycle(($urandom % 3) == 0, rb, rd, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
